// File: rtl/branch_resolution_unit.sv
// In-order tracker for predicted conditional branches: resolves each against the
// EX outcome, feeds the predictor, and redirects/flushes on a mispredict.
module branch_resolution_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_dec_valid,
    input  logic [ADDR_WIDTH-1:0]       i_dec_pc,
    input  logic [ADDR_WIDTH-1:0]       i_dec_target,
    input  logic                        i_dec_prediction,
    output logic                        o_dec_ready,
    input  logic                        i_ex_valid,
    input  logic                        i_ex_outcome,
    output logic                        o_fb_valid,
    output logic [ADDR_WIDTH-1:0]       o_fb_pc,
    output logic                        o_fb_prediction,
    output logic                        o_fb_outcome,
    output logic                        o_redirect_valid,
    output logic [ADDR_WIDTH-1:0]       o_redirect_pc,
    output logic                        o_flush,
    output logic [$clog2(DEPTH):0]      o_occupancy,
    output logic [CNT_WIDTH-1:0]        o_branch_count,
    output logic [CNT_WIDTH-1:0]        o_mispredict_count,
    output logic                        o_err_underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [PTR_W-1:0]      PTR_ONE   = PTR_W'(1);
    localparam logic [OCC_W-1:0]      OCC_ONE   = OCC_W'(1);
    localparam logic [OCC_W-1:0]      OCC_FULL  = OCC_W'(DEPTH);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] SLOT_SKIP = ADDR_WIDTH'(8);

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [PTR_W-1:0]       head_q, head_d, tail_q, tail_d;
    logic [OCC_W-1:0]       occ_q, occ_d;
    logic                   fb_valid_q, fb_valid_d;
    logic [ADDR_WIDTH-1:0]  fb_pc_q, fb_pc_d;
    logic                   fb_pred_q, fb_pred_d;
    logic                   fb_out_q, fb_out_d;
    logic                   redir_valid_q, redir_valid_d;
    logic [ADDR_WIDTH-1:0]  redir_pc_q, redir_pc_d;
    logic [CNT_WIDTH-1:0]   br_cnt_q, br_cnt_d;
    logic [CNT_WIDTH-1:0]   mp_cnt_q, mp_cnt_d;
    logic                   err_q, err_d;

    logic [ADDR_WIDTH-1:0]  pc_mem   [DEPTH];
    logic [ADDR_WIDTH-1:0]  tgt_mem  [DEPTH];
    logic                   pred_mem [DEPTH];

    logic                   push, pop, mispredict, push_commit;
    logic [ADDR_WIDTH-1:0]  correct_pc;

    assign o_dec_ready = (state_q == RUN) && (occ_q < OCC_FULL);
    assign push        = i_dec_valid && o_dec_ready;
    assign pop         = i_ex_valid && (occ_q != '0) && (state_q == RUN);
    assign mispredict  = pop && (pred_mem[head_q] != i_ex_outcome);
    // A push coinciding with a mispredict is on the wrong path and must not land.
    assign push_commit = push && !mispredict;
    assign correct_pc  = i_ex_outcome ? tgt_mem[head_q] : pc_mem[head_q] + SLOT_SKIP;

    always_comb begin
        state_d       = RUN;
        head_d        = head_q;
        tail_d        = tail_q;
        occ_d         = occ_q;
        fb_valid_d    = pop;
        fb_pc_d       = fb_pc_q;
        fb_pred_d     = fb_pred_q;
        fb_out_d      = fb_out_q;
        redir_valid_d = mispredict;
        redir_pc_d    = redir_pc_q;
        br_cnt_d      = br_cnt_q;
        mp_cnt_d      = mp_cnt_q;
        err_d         = err_q || (i_ex_valid && !pop);

        if (pop) begin
            fb_pc_d   = pc_mem[head_q];
            fb_pred_d = pred_mem[head_q];
            fb_out_d  = i_ex_outcome;
            if (br_cnt_q != '1) br_cnt_d = br_cnt_q + CNT_ONE;
        end

        if (mispredict) begin
            state_d    = RECOVER;
            redir_pc_d = correct_pc;
            head_d     = tail_q;
            occ_d      = '0;
            if (mp_cnt_q != '1) mp_cnt_d = mp_cnt_q + CNT_ONE;
        end else begin
            if (push_commit) tail_d = tail_q + PTR_ONE;
            if (pop)         head_d = head_q + PTR_ONE;
            if (push_commit && !pop)      occ_d = occ_q + OCC_ONE;
            else if (pop && !push_commit) occ_d = occ_q - OCC_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            head_q        <= '0;
            tail_q        <= '0;
            occ_q         <= '0;
            fb_valid_q    <= 1'b0;
            fb_pc_q       <= '0;
            fb_pred_q     <= 1'b0;
            fb_out_q      <= 1'b0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
            br_cnt_q      <= '0;
            mp_cnt_q      <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            occ_q         <= occ_d;
            fb_valid_q    <= fb_valid_d;
            fb_pc_q       <= fb_pc_d;
            fb_pred_q     <= fb_pred_d;
            fb_out_q      <= fb_out_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
            br_cnt_q      <= br_cnt_d;
            mp_cnt_q      <= mp_cnt_d;
            err_q         <= err_d;
        end
    end

    // Entry storage carries no reset; validity comes from the pointers alone.
    always_ff @(posedge clk) begin
        if (!rst && push_commit) begin
            pc_mem[tail_q]   <= i_dec_pc;
            tgt_mem[tail_q]  <= i_dec_target;
            pred_mem[tail_q] <= i_dec_prediction;
        end
    end

    assign o_fb_valid         = fb_valid_q;
    assign o_fb_pc            = fb_pc_q;
    assign o_fb_prediction    = fb_pred_q;
    assign o_fb_outcome       = fb_out_q;
    assign o_redirect_valid   = redir_valid_q;
    assign o_redirect_pc      = redir_pc_q;
    assign o_flush            = (state_q == RECOVER);
    assign o_occupancy        = occ_q;
    assign o_branch_count     = br_cnt_q;
    assign o_mispredict_count = mp_cnt_q;
    assign o_err_underflow    = err_q;

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Directed self-checking bench for branch_resolution_unit (DEPTH=4, 2-bit counters
// so saturation is reachable in a few resolves).
module tb_branch_resolution_unit;

    localparam int AW = 32;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          decValid;
    logic [AW-1:0] decPc;
    logic [AW-1:0] decTarget;
    logic          decPred;
    logic          decReady;
    logic          exValid;
    logic          exOutcome;
    logic          fbValid;
    logic [AW-1:0] fbPc;
    logic          fbPred;
    logic          fbOutcome;
    logic          redirValid;
    logic [AW-1:0] redirPc;
    logic          flush;
    logic [2:0]    occupancy;
    logic [CW-1:0] branchCount;
    logic [CW-1:0] mispredictCount;
    logic          errUnderflow;

    int testsRun = 0;
    int testsFailed = 0;

    branch_resolution_unit #(.ADDR_WIDTH(AW), .DEPTH(4), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .i_dec_valid(decValid), .i_dec_pc(decPc), .i_dec_target(decTarget),
        .i_dec_prediction(decPred), .o_dec_ready(decReady),
        .i_ex_valid(exValid), .i_ex_outcome(exOutcome),
        .o_fb_valid(fbValid), .o_fb_pc(fbPc), .o_fb_prediction(fbPred), .o_fb_outcome(fbOutcome),
        .o_redirect_valid(redirValid), .o_redirect_pc(redirPc), .o_flush(flush),
        .o_occupancy(occupancy), .o_branch_count(branchCount),
        .o_mispredict_count(mispredictCount), .o_err_underflow(errUnderflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        decValid = 1'b0; decPc = '0; decTarget = '0; decPred = 1'b0;
        exValid = 1'b0; exOutcome = 1'b0;
    endtask

    task automatic doReset();
        idleInputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic setPush(input logic [AW-1:0] pc, input logic [AW-1:0] tgt, input logic pred);
        decValid = 1'b1; decPc = pc; decTarget = tgt; decPred = pred;
    endtask

    task automatic test_reset();
        idleInputs();
        rst = 1'b1;
        setPush(32'h0000_0abc, 32'h0000_0def, 1'b1);
        exValid = 1'b1;
        tick();
        rst = 1'b0;
        idleInputs();
        testsRun++; if (decReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_ready got %b want 1", decReady); end
        testsRun++; if (occupancy !== 3'd0) begin testsFailed++; $display("[TB] FAIL reset_occ got %0d want 0", occupancy); end
        testsRun++; if ({fbValid, fbPc, fbPred, fbOutcome, redirValid, redirPc, flush} !== '0) begin
            testsFailed++; $display("[TB] FAIL reset_outputs fb=%b/%h redir=%b/%h flush=%b want all 0", fbValid, fbPc, redirValid, redirPc, flush); end
        testsRun++; if ({branchCount, mispredictCount, errUnderflow} !== '0) begin
            testsFailed++; $display("[TB] FAIL reset_stats br=%0d mp=%0d err=%b want 0", branchCount, mispredictCount, errUnderflow); end
        exValid = 1'b1;
        tick();
        exValid = 1'b0;
        testsRun++; if (errUnderflow !== 1'b1) begin testsFailed++; $display("[TB] FAIL empty_resolve_err got %b want 1", errUnderflow); end
        testsRun++; if (branchCount !== 2'd0 || fbValid !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL empty_resolve_count br=%0d fbv=%b want 0/0", branchCount, fbValid); end
        tick();
        testsRun++; if (errUnderflow !== 1'b1) begin testsFailed++; $display("[TB] FAIL err_sticky got %b want 1", errUnderflow); end
    endtask

    task automatic test_correct_predict();
        doReset();
        setPush(32'h100, 32'h200, 1'b1);
        tick();
        idleInputs();
        testsRun++; if (occupancy !== 3'd1) begin testsFailed++; $display("[TB] FAIL push_occ got %0d want 1", occupancy); end
        tick();
        exValid = 1'b1; exOutcome = 1'b1;
        tick();
        idleInputs();
        testsRun++; if (fbValid !== 1'b1 || fbPc !== 32'h100 || fbPred !== 1'b1 || fbOutcome !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL correct_fb got v=%b pc=%h p=%b o=%b want 1/100/1/1", fbValid, fbPc, fbPred, fbOutcome); end
        testsRun++; if (redirValid !== 1'b0 || flush !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL correct_noredir redir=%b flush=%b want 0/0", redirValid, flush); end
        testsRun++; if (branchCount !== 2'd1 || mispredictCount !== 2'd0 || occupancy !== 3'd0) begin
            testsFailed++; $display("[TB] FAIL correct_stats br=%0d mp=%0d occ=%0d want 1/0/0", branchCount, mispredictCount, occupancy); end
        tick();
        testsRun++; if (fbValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL fb_pulse got %b want 0", fbValid); end
    endtask

    task automatic test_mispredict();
        doReset();
        setPush(32'h100, 32'h200, 1'b1);
        tick();
        idleInputs();
        exValid = 1'b1; exOutcome = 1'b0;
        tick();
        idleInputs();
        testsRun++; if (redirValid !== 1'b1 || redirPc !== 32'h108) begin
            testsFailed++; $display("[TB] FAIL mp_redirect got v=%b pc=%h want 1/108", redirValid, redirPc); end
        testsRun++; if (flush !== 1'b1 || decReady !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL mp_recover flush=%b ready=%b want 1/0", flush, decReady); end
        testsRun++; if (fbValid !== 1'b1 || fbOutcome !== 1'b0 || mispredictCount !== 2'd1 || branchCount !== 2'd1) begin
            testsFailed++; $display("[TB] FAIL mp_fb v=%b o=%b mp=%0d br=%0d want 1/0/1/1", fbValid, fbOutcome, mispredictCount, branchCount); end
        tick();
        testsRun++; if (redirValid !== 1'b0 || flush !== 1'b0 || decReady !== 1'b1 || fbValid !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL mp_oneshot redir=%b flush=%b ready=%b fbv=%b want 0/0/1/0", redirValid, flush, decReady, fbValid); end
    endtask

    task automatic test_full_wrap();
        logic [AW-1:0] expPc [4];
        doReset();
        for (int k = 0; k < 4; k++) begin
            setPush(32'h1000 + 32'(k) * 32'h10, 32'h9000, 1'b0);
            tick();
        end
        idleInputs();
        testsRun++; if (occupancy !== 3'd4 || decReady !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL full_state occ=%0d ready=%b want 4/0", occupancy, decReady); end
        setPush(32'h500, 32'h600, 1'b0);
        exValid = 1'b1; exOutcome = 1'b0;
        tick();
        idleInputs();
        testsRun++; if (occupancy !== 3'd3 || fbPc !== 32'h1000 || decReady !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL full_refuse occ=%0d fbpc=%h ready=%b want 3/1000/1", occupancy, fbPc, decReady); end
        setPush(32'h1040, 32'h9000, 1'b0);
        tick();
        idleInputs();
        testsRun++; if (occupancy !== 3'd4) begin testsFailed++; $display("[TB] FAIL wrap_push occ=%0d want 4", occupancy); end
        expPc[0] = 32'h1010; expPc[1] = 32'h1020; expPc[2] = 32'h1030; expPc[3] = 32'h1040;
        for (int k = 0; k < 4; k++) begin
            exValid = 1'b1; exOutcome = 1'b0;
            tick();
            idleInputs();
            testsRun++; if (fbValid !== 1'b1 || fbPc !== expPc[k] || redirValid !== 1'b0) begin
                testsFailed++; $display("[TB] FAIL fifo_order[%0d] v=%b pc=%h redir=%b want 1/%h/0", k, fbValid, fbPc, redirValid, expPc[k]); end
        end
        testsRun++; if (occupancy !== 3'd0 || branchCount !== 2'd3 || errUnderflow !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL drain occ=%0d br=%0d err=%b want 0/3/0", occupancy, branchCount, errUnderflow); end
    endtask

    task automatic test_mispredict_flush();
        doReset();
        setPush(32'h2000, 32'h400, 1'b0); tick();
        setPush(32'h2010, 32'h410, 1'b1); tick();
        setPush(32'h2020, 32'h420, 1'b1); tick();
        idleInputs();
        testsRun++; if (occupancy !== 3'd3) begin testsFailed++; $display("[TB] FAIL flush_pre occ=%0d want 3", occupancy); end
        setPush(32'h3000, 32'h3100, 1'b1);
        exValid = 1'b1; exOutcome = 1'b1;
        tick();
        idleInputs();
        testsRun++; if (redirValid !== 1'b1 || redirPc !== 32'h400 || occupancy !== 3'd0 || flush !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL flush_redirect v=%b pc=%h occ=%0d flush=%b want 1/400/0/1", redirValid, redirPc, occupancy, flush); end
        exValid = 1'b1; exOutcome = 1'b1;
        tick();
        idleInputs();
        testsRun++; if (errUnderflow !== 1'b1 || branchCount !== 2'd1 || fbValid !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL recover_resolve err=%b br=%0d fbv=%b want 1/1/0", errUnderflow, branchCount, fbValid); end
        testsRun++; if (occupancy !== 3'd0 || decReady !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL post_recover occ=%0d ready=%b want 0/1", occupancy, decReady); end
        setPush(32'h5000, 32'h5100, 1'b1);
        tick();
        idleInputs();
        exValid = 1'b1; exOutcome = 1'b1;
        tick();
        idleInputs();
        testsRun++; if (fbPc !== 32'h5000 || redirValid !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL after_flush fbpc=%h redir=%b want 5000/0", fbPc, redirValid); end
    endtask

    task automatic test_saturate_reset();
        logic [CW-1:0] expCnt;
        doReset();
        exValid = 1'b1;
        tick();
        idleInputs();
        for (int k = 0; k < 5; k++) begin
            setPush((k == 0) ? 32'hFFFF_FFFC : 32'h7000 + 32'(k) * 32'h20, 32'h8000, 1'b1);
            tick();
            idleInputs();
            exValid = 1'b1; exOutcome = 1'b0;
            tick();
            idleInputs();
            expCnt = (k < 3) ? CW'(k + 1) : 2'd3;
            testsRun++; if (branchCount !== expCnt || mispredictCount !== expCnt) begin
                testsFailed++; $display("[TB] FAIL sat_count[%0d] br=%0d mp=%0d want %0d", k, branchCount, mispredictCount, expCnt); end
            if (k == 0) begin
                testsRun++; if (redirPc !== 32'h0000_0004) begin
                    testsFailed++; $display("[TB] FAIL pc_wrap got %h want 00000004", redirPc); end
            end
            if (k < 4) tick();
        end
        testsRun++; if (flush !== 1'b1 || errUnderflow !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL pre_reset flush=%b err=%b want 1/1", flush, errUnderflow); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        testsRun++; if ({fbValid, fbPc, fbPred, fbOutcome, redirValid, redirPc, flush} !== '0) begin
            testsFailed++; $display("[TB] FAIL midrecover_outputs fb=%b/%h redir=%b/%h flush=%b want all 0", fbValid, fbPc, redirValid, redirPc, flush); end
        testsRun++; if ({branchCount, mispredictCount, errUnderflow, occupancy} !== '0 || decReady !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL midrecover_stats br=%0d mp=%0d err=%b occ=%0d ready=%b want 0/0/0/0/1",
                branchCount, mispredictCount, errUnderflow, occupancy, decReady); end
    endtask

    initial begin
        idleInputs();
        rst = 1'b1;
        test_reset();
        test_correct_predict();
        test_mispredict();
        test_full_wrap();
        test_mispredict_flush();
        test_saturate_reset();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/branch_resolution_unit.md
Name: branch_resolution_unit

Overview:
- Execute-side counterpart of the branch predictor request path.
- Tracks every conditional branch that received a prediction at decode in an in-order queue.
- Resolves each branch against the actual outcome from EX, and drives the predictor feedback bundle (valid, pc, prediction, outcome).
- On a mispredict, issues a registered redirect, a flush, and a squash of younger in-flight branches. Also keeps branch and mispredict statistics.

Parameters:
- ADDR_WIDTH, 32, width of PC and target fields.
- DEPTH, 4, in-flight branch queue entries; power of two, at least 2.
- CNT_WIDTH, 32, width of the statistics counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- i_dec_valid  in  1  decode presents a predicted conditional branch.
- i_dec_pc  in  ADDR_WIDTH  branch PC.
- i_dec_target  in  ADDR_WIDTH  taken target.
- i_dec_prediction  in  1  1=TAKEN, 0=NOT_TAKEN.
- o_dec_ready  out  1  push accepted this cycle when high.
- i_ex_valid  in  1  EX resolves the oldest in-flight branch.
- i_ex_outcome  in  1  1=TAKEN, 0=NOT_TAKEN.
- o_fb_valid  out  1  predictor feedback strobe.
- o_fb_pc  out  ADDR_WIDTH  resolved branch PC.
- o_fb_prediction  out  1  prediction stored at decode.
- o_fb_outcome  out  1  actual outcome.
- o_redirect_valid  out  1  fetch redirect on mispredict.
- o_redirect_pc  out  ADDR_WIDTH  correct-path PC.
- o_flush  out  1  squash younger pipeline state.
- o_occupancy  out  $clog2(DEPTH)+1  entries in queue.
- o_branch_count  out  CNT_WIDTH  resolved branches, saturating.
- o_mispredict_count  out  CNT_WIDTH  mispredicts, saturating.
- o_err_underflow  out  1  sticky; set when a resolve arrives with the queue empty.

Behaviour:
- Reset (rst=1 at posedge):
  - Queue emptied (head=tail=0, occupancy 0); state RUN.
  - All o_fb_*, o_redirect_*, o_flush, counters and o_err_underflow cleared to 0.
  - Reset overrides every simultaneous push or resolve.
- Controller states:
  - RUN: normal operation.
  - RECOVER: lasts exactly one cycle and is entered at the edge that registers a mispredict. o_flush=1 and o_dec_ready=0 throughout; returns to RUN at the next edge.
- o_dec_ready = (state==RUN) && (occupancy<DEPTH); combinational. The push condition is i_dec_valid && o_dec_ready.
- Full queue: a push is refused even if a pop happens in the same cycle. No bypass.
- Resolve (pop) = i_ex_valid && occupancy>0 && state==RUN. It always consumes the head entry, in order.
- Resolve while the queue is empty, or while in RECOVER: ignored, and o_err_underflow is set (sticky until rst).
- Feedback latency is 1 cycle. At the edge after a resolve:
  - o_fb_valid=1, with o_fb_pc, o_fb_prediction and o_fb_outcome from the head entry and i_ex_outcome.
  - o_fb_valid is 0 in every other cycle.
- mispredict = head.prediction != i_ex_outcome.
- Correct PC = head.target if outcome TAKEN, else head.pc + 8 (delay slot), computed modulo 2^ADDR_WIDTH.
- On a mispredicting resolve, at the same edge that registers feedback:
  - o_redirect_valid=1 and o_redirect_pc=correct PC, held for one cycle only.
  - State moves to RECOVER; every remaining queue entry is discarded (occupancy becomes 0, head=tail).
  - A push in the same cycle is discarded, because it is wrong-path.
- On a correctly predicted resolve: no redirect, no flush. A simultaneous push is accepted, so occupancy is unchanged.
- Push alone: occupancy+1. Pop alone: occupancy-1. Pointers wrap modulo DEPTH.
- o_branch_count increments on each resolve. o_mispredict_count increments on each mispredicting resolve. Both saturate at all-ones.
- Queue storage needs no reset; only the pointers and occupancy are reset.

Test Plan:
- Reset then idle: o_dec_ready=1, occupancy 0, all outputs 0; a resolve with the queue empty sets o_err_underflow=1 and does not change the counters.
- Push {pc=0x100, tgt=0x200, pred=1}; resolve outcome=1 two cycles later: one cycle after the resolve, o_fb_valid=1, pc=0x100, pred=1, outcome=1; no redirect; branch_count=1.
- Push {pc=0x100, tgt=0x200, pred=1}; resolve outcome=0: o_redirect_pc=0x108, redirect and flush each high for one cycle, o_dec_ready=0 during RECOVER, mispredict_count=1.
- Push 4 branches (DEPTH=4): o_dec_ready=0, and a 5th push in a cycle with a correct resolve is refused (occupancy 4→3); the next push is accepted and entries pop in FIFO order across pointer wrap.
- Occupancy 3; mispredict on the head {pred=0, tgt=0x400} with a simultaneous push: redirect 0x400, occupancy becomes 0, and a resolve on the following cycle sets o_err_underflow.
- With CNT_WIDTH=2, 5 mispredicting resolves: both counters saturate at 3; assert rst mid-RECOVER and all outputs return to 0 on the next cycle.
